// File: rtl/wb_regfile.sv
// Integer register file: two bypassed decode read ports, one raw debug port,
// x0 hardwired to zero, plus a free-running count of committed writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] Rd_W,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] DBG_A,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] DBG_RD,
    output logic [31:0]       WR_COUNT
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG-1:1];
    logic [31:0]       r_wr_count;

    logic              w_we;
    logic [DATA_W-1:0] w_arr1;
    logic [DATA_W-1:0] w_arr2;
    logic [DATA_W-1:0] w_arr_dbg;

    // Only RegWriteW and Rd_W gate state, so X on idle read indices is harmless
    assign w_we = RegWriteW && (Rd_W != '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[Rd_W] <= ResultW;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_count <= '0;
        end else if (w_we) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    // Index 0 matches no entry and falls through to zero
    always_comb begin
        w_arr1    = '0;
        w_arr2    = '0;
        w_arr_dbg = '0;
        for (int i = 1; i < NREG; i++) begin
            if (A1 == ADDR_W'(i)) begin
                w_arr1 = r_regs[i];
            end
            if (A2 == ADDR_W'(i)) begin
                w_arr2 = r_regs[i];
            end
            if (DBG_A == ADDR_W'(i)) begin
                w_arr_dbg = r_regs[i];
            end
        end
    end

    assign RD1      = (w_we && (Rd_W == A1)) ? ResultW : w_arr1;
    assign RD2      = (w_we && (Rd_W == A2)) ? ResultW : w_arr2;
    assign DBG_RD   = w_arr_dbg;
    assign WR_COUNT = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, X-input
// and counter-wrap sequences.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  Rd_W = '0;
    logic [31:0] ResultW = '0;
    logic [4:0]  A1 = '0;
    logic [4:0]  A2 = '0;
    logic [4:0]  DBG_A = '0;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] DBG_RD;
    logic [31:0] WR_COUNT;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .RegWriteW(RegWriteW), .Rd_W(Rd_W), .ResultW(ResultW),
        .A1(A1), .A2(A2), .DBG_A(DBG_A),
        .RD1(RD1), .RD2(RD2), .DBG_RD(DBG_RD),
        .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  da;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_dbg;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd,
                         input logic [31:0] res, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] da);
        RegWriteW = we;
        Rd_W      = rd;
        ResultW   = res;
        A1        = a1;
        A2        = a2;
        DBG_A     = da;
    endtask

    initial begin
        // Counts are those visible before the row's own edge
        vec[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,
                    32'hDEADBEEF, 32'h0, 32'h0, 32'd0};
        vec[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vec[2]  = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd5,  5'd7,
                    32'h1, 32'hDEADBEEF, 32'h0, 32'd1};
        vec[3]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  5'd7,
                    32'h12345678, 32'h12345678, 32'h1, 32'd2};
        vec[4]  = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  5'd7,
                    32'h12345678, 32'h12345678, 32'h12345678, 32'd3};
        vec[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  5'd0,
                    32'h0, 32'h12345678, 32'h0, 32'd3};
        vec[6]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,
                    32'h0, 32'h0, 32'h0, 32'd3};
        vec[7]  = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd5,  5'd9,  5'd9,
                    32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 32'd3};
        vec[8]  = '{1'b0, 5'd9,  32'h0,        5'd9,  5'd31, 5'd9,
                    32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'd4};
        vec[9]  = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd9,  5'd31,
                    32'h80000001, 32'hCAFEF00D, 32'h0, 32'd4};
        vec[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31,
                    32'h80000001, 32'h80000001, 32'h80000001, 32'd5};
        vec[11] = '{1'b1, 5'd5,  32'h00000055, 5'd5,  5'd5,  5'd5,
                    32'h55, 32'h55, 32'hDEADBEEF, 32'd5};
        vec[12] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 5'd5,
                    32'h55, 32'h80000001, 32'h55, 32'd6};

        // Reset pulse between edges, then sweep every index
        #2 RST = 1'b0;
        #1 RST = 1'b1;
        chk("rst cnt", WR_COUNT, 32'h0);
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            DBG_A = 5'(i);
            #1;
            chk($sformatf("rst rd1[%0d]", i), RD1, 32'h0);
            chk($sformatf("rst rd2[%0d]", 31 - i), RD2, 32'h0);
            chk($sformatf("rst dbg[%0d]", i), DBG_RD, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            drive(vec[i].we, vec[i].rd, vec[i].res,
                  vec[i].a1, vec[i].a2, vec[i].da);
            #1;
            chk($sformatf("v%0d rd1", i), RD1, vec[i].e_rd1);
            chk($sformatf("v%0d rd2", i), RD2, vec[i].e_rd2);
            chk($sformatf("v%0d dbg", i), DBG_RD, vec[i].e_dbg);
            chk($sformatf("v%0d cnt", i), WR_COUNT, vec[i].e_cnt);
        end

        // X on idle ports must not disturb state
        @(negedge CLK);
        drive(1'b0, 'x, 'x, 'x, 'x, 5'd5);
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 5'd5);
        #1;
        chk("x dbg5", DBG_RD, 32'h55);
        chk("x rd1 9", RD1, 32'hCAFEF00D);
        chk("x rd2 31", RD2, 32'h80000001);
        chk("x cnt", WR_COUNT, 32'd6);

        // Reset mid-stream discards the in-flight write
        @(negedge CLK);
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0, 5'd3);
        @(negedge CLK);
        drive(1'b1, 5'd4, 32'h5A5A5A5A, 5'd4, 5'd3, 5'd3);
        #1;
        chk("pre-rst dbg3", DBG_RD, 32'hA5A5A5A5);
        chk("pre-rst cnt", WR_COUNT, 32'd7);
        RST = 1'b0;
        #1;
        chk("in-rst dbg3", DBG_RD, 32'h0);
        chk("in-rst rd1 byp", RD1, 32'h5A5A5A5A);
        chk("in-rst rd2", RD2, 32'h0);
        chk("in-rst cnt", WR_COUNT, 32'h0);
        @(negedge CLK);
        chk("held-rst cnt", WR_COUNT, 32'h0);
        RST = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd4);
        #1;
        chk("post-rst rd1 x3", RD1, 32'h0);
        chk("post-rst rd2 x4", RD2, 32'h0);
        chk("post-rst dbg x4", DBG_RD, 32'h0);
        chk("post-rst cnt", WR_COUNT, 32'h0);
        @(negedge CLK);
        drive(1'b1, 5'd4, 32'h1, 5'd0, 5'd0, 5'd4);
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 5'd4);
        #1;
        chk("rel wr rd1", RD1, 32'h1);
        chk("rel wr dbg", DBG_RD, 32'h1);
        chk("rel wr cnt", WR_COUNT, 32'd1);

        // Counter wrap via backdoor preload
        @(negedge CLK);
        dut.r_wr_count = 32'hFFFFFFFE;
        drive(1'b1, 5'd10, 32'h10, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        drive(1'b1, 5'd11, 32'h11, 5'd0, 5'd0, 5'd0);
        #1;
        chk("wrap cnt1", WR_COUNT, 32'hFFFFFFFF);
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd11, 5'd11);
        #1;
        chk("wrap cnt0", WR_COUNT, 32'h0);
        chk("wrap rd1 x10", RD1, 32'h10);
        chk("wrap rd2 x11", RD2, 32'h11);
        chk("wrap dbg x11", DBG_RD, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
